// File: rtl/fetch_sequencer.sv
// Instruction fetch/sequencing front-end for the 4-bit processor: 16x8 program
// store, program counter, instruction register and the fetch/decode/execute FSM.
module fetch_sequencer #(
  parameter int PROG_DEPTH = 16
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       start,
  input  logic       prog_we,
  input  logic [3:0] prog_addr,
  input  logic [7:0] prog_data,
  input  logic       jump,
  output logic [3:0] opcode,
  output logic [3:0] operand,
  output logic       instr_valid,
  output logic [3:0] pc,
  output logic       busy,
  output logic       halted
);

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_FETCH   = 3'd1,
    S_DECODE  = 3'd2,
    S_EXECUTE = 3'd3,
    S_HALT    = 3'd4
  } state_t;

  localparam logic [3:0] OP_HLT = 4'hF;

  state_t     state_q, state_d;
  logic [3:0] pc_q, pc_d;
  logic [7:0] ir_q, ir_d;
  logic       instr_valid_q, busy_q, halted_q;
  logic       prog_open;

  logic [7:0] mem [PROG_DEPTH];

  assign prog_open = (state_q == S_IDLE) || (state_q == S_HALT);

  // Store is deliberately outside the reset domain so a program survives reset.
  always_ff @(posedge clk) begin
    if (prog_we && prog_open) begin
      mem[prog_addr] <= prog_data;
    end
  end

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    ir_d    = ir_q;
    case (state_q)
      S_IDLE, S_HALT: begin
        if (start) begin
          pc_d    = 4'd0;
          state_d = S_FETCH;
        end
      end
      S_FETCH: begin
        ir_d    = mem[pc_q];
        state_d = S_DECODE;
      end
      S_DECODE: begin
        state_d = (ir_q[7:4] == OP_HLT) ? S_HALT : S_EXECUTE;
      end
      S_EXECUTE: begin
        pc_d    = jump ? ir_q[3:0] : pc_q + 4'd1;
        state_d = S_FETCH;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // Status outputs are decoded from the next state so they line up with state_q.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q       <= S_IDLE;
      pc_q          <= 4'd0;
      ir_q          <= 8'h00;
      instr_valid_q <= 1'b0;
      busy_q        <= 1'b0;
      halted_q      <= 1'b0;
    end else begin
      state_q       <= state_d;
      pc_q          <= pc_d;
      ir_q          <= ir_d;
      instr_valid_q <= (state_d == S_EXECUTE);
      busy_q        <= (state_d == S_FETCH) || (state_d == S_DECODE) ||
                       (state_d == S_EXECUTE);
      halted_q      <= (state_d == S_HALT);
    end
  end

  assign opcode      = ir_q[7:4];
  assign operand     = ir_q[3:0];
  assign pc          = pc_q;
  assign instr_valid = instr_valid_q;
  assign busy        = busy_q;
  assign halted      = halted_q;

endmodule

// File: tb/tb_fetch_sequencer.sv
// Bench for fetch_sequencer: directed program table, hand-written corner
// sequences and random programs checked against an instruction-level model.
module tb_fetch_sequencer;

  logic       clk = 1'b0;
  logic       reset, start, prog_we, jump;
  logic [3:0] prog_addr, opcode, operand, pc;
  logic [7:0] prog_data;
  logic       instr_valid, busy, halted;
  logic [15:0] jmask;

  int checks;
  int failures;

  always #5 clk = ~clk;

  // Control-unit stand-in: jump decided purely by the presented opcode.
  assign jump = jmask[opcode];

  fetch_sequencer #(.PROG_DEPTH(16)) dut (
    .clk(clk), .reset(reset), .start(start), .prog_we(prog_we),
    .prog_addr(prog_addr), .prog_data(prog_data), .jump(jump),
    .opcode(opcode), .operand(operand), .instr_valid(instr_valid),
    .pc(pc), .busy(busy), .halted(halted)
  );

  // Shadow of the program store and the model's predicted execution trace.
  logic [7:0] img [16];
  int         m_n;
  bit         m_h;
  logic [3:0] m_fpc;
  logic [3:0] m_pc [64];
  logic [7:0] m_w  [64];

  int         o_n;
  logic [7:0] o_w0;
  logic [3:0] o_pc;
  logic       o_h;

  typedef struct {
    logic [3:0][7:0] w;
    logic [3:0][3:0] a;
    int              nw;
    logic [15:0]     jm;
    int              en;
    logic [3:0]      epc;
    logic [7:0]      ew0;
    logic            eh;
  } vec_t;

  vec_t vec [4];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // Walks the program one instruction at a time from address 0.
  task automatic model(input int maxn);
    logic [3:0] p;
    logic [7:0] w;
    p = 4'd0; m_n = 0; m_h = 1'b0;
    while (m_n < maxn && !m_h) begin
      w = img[p];
      if (w[7:4] == 4'hF) begin
        m_h = 1'b1;
      end else begin
        m_pc[m_n] = p;
        m_w[m_n]  = w;
        m_n++;
        p = jmask[w[7:4]] ? w[3:0] : p + 4'd1;
      end
    end
    m_fpc = p;
  endtask

  task automatic load(input logic [3:0] a, input logic [7:0] d);
    @(negedge clk);
    prog_we = 1'b1; prog_addr = a; prog_data = d;
    @(negedge clk);
    prog_we = 1'b0;
    img[a] = d;
  endtask

  // wr_at == 0: write together with start; wr_at > 0: write and start while busy.
  task automatic run(input int maxn, input int wr_at, input logic [3:0] wa, input logic [7:0] wd);
    int cyc, hcyc;
    if (wr_at == 0) img[wa] = wd;
    model(maxn);
    @(negedge clk);
    start = 1'b1;
    if (wr_at == 0) begin
      prog_we = 1'b1; prog_addr = wa; prog_data = wd;
    end
    @(posedge clk);
    #1;
    start = 1'b0; prog_we = 1'b0;
    cyc = 0; hcyc = -1; o_n = 0; o_w0 = 8'hxx;
    while (hcyc < 0 && o_n < maxn && cyc < 3 * maxn + 6) begin
      @(negedge clk);
      cyc++;
      start = 1'b0; prog_we = 1'b0;
      chk("busy_halted_excl", 32'(busy & halted), 32'd0);
      if (instr_valid) begin
        if (o_n == 0) o_w0 = {opcode, operand};
        if (o_n < m_n) begin
          chk("iv_cycle", cyc, 3 * (o_n + 1));
          chk("iv_pc", 32'(pc), 32'(m_pc[o_n]));
          chk("iv_word", 32'({opcode, operand}), 32'(m_w[o_n]));
        end else begin
          chk("extra_instr", o_n, m_n);
        end
        o_n++;
        if (o_n == wr_at) begin
          start = 1'b1; prog_we = 1'b1; prog_addr = wa; prog_data = wd;
        end
      end
      if (halted) hcyc = cyc;
      else chk("busy_running", 32'(busy), 32'd1);
    end
    o_pc = pc; o_h = halted;
    chk("instr_count", o_n, m_n);
    chk("halted_end", 32'(halted), 32'(m_h));
    if (m_h) begin
      chk("halt_cycle", hcyc, 3 * m_n + 3);
      chk("halt_pc", 32'(pc), 32'(m_fpc));
    end
  endtask

  task automatic abort_run();
    reset = 1'b1;
    #1;
    chk("reset_async", 32'({instr_valid, busy, halted, pc, opcode, operand}), 32'd0);
    @(negedge clk);
    reset = 1'b0;
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    checks = 0; failures = 0;
    reset = 1'b1; start = 1'b0; prog_we = 1'b0;
    prog_addr = 4'd0; prog_data = 8'h00; jmask = 16'h0;

    vec[0].w = {8'h00, 8'hF0, 8'h22, 8'h13}; vec[0].a = {4'd0, 4'd2, 4'd1, 4'd0};
    vec[0].nw = 3; vec[0].jm = 16'h0000; vec[0].en = 2; vec[0].epc = 4'd2;
    vec[0].ew0 = 8'h13; vec[0].eh = 1'b1;
    vec[1].w = {8'h00, 8'h00, 8'hF0, 8'h75}; vec[1].a = {4'd0, 4'd0, 4'd5, 4'd0};
    vec[1].nw = 2; vec[1].jm = 16'h0080; vec[1].en = 1; vec[1].epc = 4'd5;
    vec[1].ew0 = 8'h75; vec[1].eh = 1'b1;
    vec[2].w = {8'h00, 8'h00, 8'hF0, 8'h89}; vec[2].a = {4'd0, 4'd0, 4'd1, 4'd0};
    vec[2].nw = 2; vec[2].jm = 16'h0000; vec[2].en = 1; vec[2].epc = 4'd1;
    vec[2].ew0 = 8'h89; vec[2].eh = 1'b1;
    vec[3].w = {8'h00, 8'h00, 8'h00, 8'hF0}; vec[3].a = {4'd0, 4'd0, 4'd0, 4'd0};
    vec[3].nw = 1; vec[3].jm = 16'h0000; vec[3].en = 0; vec[3].epc = 4'd0;
    vec[3].ew0 = 8'h00; vec[3].eh = 1'b1;

    repeat (2) @(negedge clk);
    chk("reset_values", 32'({state_bits_zero(), instr_valid, busy, halted, pc}), 32'd0);
    reset = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      chk("idle_hold", 32'({instr_valid, busy, halted, pc}), 32'd0);
    end

    for (int i = 0; i < 4; i++) begin
      for (int k = 0; k < 16; k++) load(4'(k), 8'hF0);
      for (int j = 0; j < vec[i].nw; j++) load(vec[i].a[j], vec[i].w[j]);
      jmask = vec[i].jm;
      run(10, -1, 4'd0, 8'h00);
      chk("tbl_count", o_n, vec[i].en);
      chk("tbl_pc", 32'(o_pc), 32'(vec[i].epc));
      chk("tbl_halted", 32'(o_h), 32'(vec[i].eh));
      if (vec[i].en > 0) chk("tbl_first_word", 32'(o_w0), 32'(vec[i].ew0));
    end

    // Write and start in the same cycle from HALT: the new word is fetched.
    jmask = 16'h0;
    run(10, 0, 4'd0, 8'h13);
    chk("same_cycle_wr_word", 32'(o_w0), 32'h13);
    chk("same_cycle_wr_pc", 32'(o_pc), 32'd1);

    // All-NOP wrap with a write and start attempted while busy.
    for (int k = 0; k < 16; k++) load(4'(k), 8'h00);
    run(20, 3, 4'd1, 8'hF0);
    chk("wrap_no_halt", 32'(o_h), 32'd0);
    chk("wrap_last_pc", 32'(o_pc), 32'd3);
    chk("wrap_in_execute", 32'(instr_valid), 32'd1);
    abort_run();

    for (int r = 0; r < 8; r++) begin
      for (int k = 0; k < 16; k++) load(4'(k), 8'($urandom));
      jmask = 16'($urandom);
      run(30, -1, 4'd0, 8'h00);
      if (!o_h) abort_run();
    end

    // Program must survive a reset.
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    run(30, -1, 4'd0, 8'h00);
    if (!o_h) abort_run();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  function automatic logic [7:0] state_bits_zero();
    return {opcode, operand};
  endfunction

endmodule
